// File: rtl/i2c_byte_master.sv
// i2c_byte_master: single-byte I2C write/read sequencer driven by the data_clk phase clock
//   clk, rst (sync, active-low)   data_clk  rise = mid SCL-low, fall = mid SCL-high
//   start_req/addr/rw/wr_data     request, captured when busy=0
//   sda_in                        sampled SDA
//   sda_oe, scl_not_ena, busy     open-drain SDA pull, SCL enable (low = clocking), activity
//   rd_data, rd_valid, ack_err    read result, one-cycle update pulse, slave NACK flag
module i2c_byte_master #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_clk,
    input  logic              start_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rw,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic              scl_not_ena,
    output logic              busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ack_err
);
    localparam int CW = $clog2((ADDR_W + 1) > DATA_W ? ADDR_W + 1 : DATA_W);
    typedef enum logic [3:0] {IDLE, START, ADDR, SACK1, WR, SACK2, RD, MACK, STOP} state_t;
    state_t            state;
    logic [ADDR_W:0]   sh_a;
    logic [DATA_W-1:0] sh_d;
    logic [DATA_W-1:0] rd_sh;
    logic [CW-1:0]     bit_cnt;
    logic              dclk_q;
    logic              rise;
    logic              fall;
    assign rise = data_clk & ~dclk_q;
    assign fall = ~data_clk & dclk_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            sda_oe      <= 1'b0;
            scl_not_ena <= 1'b1;
            busy        <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            ack_err     <= 1'b0;
            dclk_q      <= 1'b0;
            sh_a        <= '0;
            sh_d        <= '0;
            rd_sh       <= '0;
            bit_cnt     <= '0;
        end else begin
            dclk_q   <= data_clk;
            rd_valid <= 1'b0;
            if (start_req && !busy) begin
                sh_a    <= {addr, rw};
                sh_d    <= wr_data;
                busy    <= 1'b1;
                ack_err <= 1'b0;
            end
            case (state)
                IDLE: if (busy && fall) begin
                    sda_oe      <= 1'b1;
                    scl_not_ena <= 1'b0;
                    state       <= START;
                end
                START: if (rise) begin
                    state   <= ADDR;
                    bit_cnt <= CW'(ADDR_W);
                    sda_oe  <= ~sh_a[ADDR_W];
                end
                // bit_cnt indexes the bit currently on the line
                ADDR: if (rise) begin
                    if (bit_cnt == '0) begin
                        state  <= SACK1;
                        sda_oe <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        sda_oe  <= ~sh_a[bit_cnt - 1'b1];
                    end
                end
                SACK1: begin
                    if (fall && sda_in) ack_err <= 1'b1;
                    if (rise) begin
                        if (ack_err) begin
                            state  <= STOP;
                            sda_oe <= 1'b1;
                        end else if (sh_a[0]) begin
                            state   <= RD;
                            bit_cnt <= CW'(DATA_W - 1);
                            sda_oe  <= 1'b0;
                        end else begin
                            state   <= WR;
                            bit_cnt <= CW'(DATA_W - 1);
                            sda_oe  <= ~sh_d[DATA_W-1];
                        end
                    end
                end
                WR: if (rise) begin
                    if (bit_cnt == '0) begin
                        state  <= SACK2;
                        sda_oe <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                        sda_oe  <= ~sh_d[bit_cnt - 1'b1];
                    end
                end
                SACK2: begin
                    if (fall && sda_in) ack_err <= 1'b1;
                    if (rise) begin
                        state  <= STOP;
                        sda_oe <= 1'b1;
                    end
                end
                RD: begin
                    if (fall) rd_sh <= {rd_sh[DATA_W-2:0], sda_in};
                    if (rise) begin
                        if (bit_cnt == '0) begin
                            state    <= MACK;
                            rd_data  <= rd_sh;
                            rd_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                end
                // SDA stays released here: the master NACK ends the read
                MACK: if (rise) begin
                    state  <= STOP;
                    sda_oe <= 1'b1;
                end
                // SDA rising while SCL is high forms the STOP condition
                STOP: if (fall) begin
                    sda_oe      <= 1'b0;
                    scl_not_ena <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: directed checks of write, NACK, read, ignored request, reset abort and stretching
module tb_i2c_byte_master;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_clk = 1'b0;
    logic       start_req = 1'b0;
    logic [6:0] addr = '0;
    logic       rw = 1'b0;
    logic [7:0] wr_data = '0;
    logic       sda_in = 1'b1;
    logic       sda_oe;
    logic       scl_not_ena;
    logic       busy;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       ack_err;
    int         checks = 0;
    int         errors = 0;
    int         vcnt = 0;

    i2c_byte_master dut (
        .clk(clk), .rst(rst), .data_clk(data_clk), .start_req(start_req),
        .addr(addr), .rw(rw), .wr_data(wr_data), .sda_in(sda_in),
        .sda_oe(sda_oe), .scl_not_ena(scl_not_ena), .busy(busy),
        .rd_data(rd_data), .rd_valid(rd_valid), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rd_valid) vcnt++;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rise();
        @(negedge clk) data_clk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic fall();
        @(negedge clk) data_clk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic req(input logic [6:0] a, input logic r, input logic [7:0] d);
        addr = a;
        rw = r;
        wr_data = d;
        @(negedge clk) start_req = 1'b1;
        @(negedge clk) start_req = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_ack_err", ack_err, 0);
        check("accept_sda_oe", sda_oe, 0);
        check("accept_scl_ne", scl_not_ena, 1);
    endtask

    task automatic hdr(input logic [6:0] a, input logic r, input logic nack, input logic stretch);
        logic [7:0] sh;
        sh = {a, r};
        rise;
        check("idle_rise_sda_oe", sda_oe, 0);
        fall;
        check("start_sda_oe", sda_oe, 1);
        check("start_scl_ne", scl_not_ena, 0);
        for (int i = 7; i >= 0; i--) begin
            rise;
            check("addr_bit", sda_oe, !sh[i]);
            if (stretch && i == 5) begin
                repeat (50) @(negedge clk);
                check("stretch_sda_oe", sda_oe, !sh[i]);
                check("stretch_busy", busy, 1);
            end
            fall;
        end
        rise;
        check("sack1_release", sda_oe, 0);
        sda_in = nack;
        fall;
        check("sack1_ack_err", ack_err, nack);
        sda_in = 1'b1;
    endtask

    task automatic wr_byte(input logic [7:0] d, input logic disturb);
        for (int i = 7; i >= 0; i--) begin
            rise;
            check("data_bit", sda_oe, !d[i]);
            if (disturb && i == 4) begin
                addr = 7'h7F;
                wr_data = 8'hFF;
                rw = 1'b1;
                @(negedge clk) start_req = 1'b1;
                @(negedge clk) start_req = 1'b0;
                check("ignored_req_busy", busy, 1);
            end
            fall;
        end
        rise;
        check("sack2_release", sda_oe, 0);
        sda_in = 1'b0;
        fall;
        check("sack2_ack_err", ack_err, 0);
        sda_in = 1'b1;
    endtask

    task automatic rd_byte(input logic [7:0] d);
        int v0;
        v0 = vcnt;
        rise;
        check("rd_release", sda_oe, 0);
        sda_in = d[7];
        fall;
        for (int i = 6; i >= 0; i--) begin
            rise;
            check("rd_release", sda_oe, 0);
            sda_in = d[i];
            fall;
        end
        rise;
        check("mack_release", sda_oe, 0);
        check("rd_data", rd_data, d);
        check("rd_valid_pulses", vcnt - v0, 1);
        sda_in = 1'b1;
        fall;
        check("rd_valid_pulses_after", vcnt - v0, 1);
    endtask

    task automatic stop();
        rise;
        check("stop_sda_low", sda_oe, 1);
        check("stop_busy", busy, 1);
        check("stop_scl_ne", scl_not_ena, 0);
        fall;
        check("stop_release", sda_oe, 0);
        check("stop_scl_idle", scl_not_ena, 1);
        check("stop_busy_drop", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_scl_ne", scl_not_ena, 1);
        check("rst_busy", busy, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_ack_err", ack_err, 0);
        rst = 1'b1;
        @(negedge clk);
        // write 0x50 <- 0xA5, both ACKed
        req(7'h50, 1'b0, 8'hA5);
        hdr(7'h50, 1'b0, 1'b0, 1'b0);
        wr_byte(8'hA5, 1'b0);
        stop;
        check("t1_ack_err", ack_err, 0);
        // address NACK: STOP follows SACK1 with no data byte
        req(7'h11, 1'b0, 8'hFF);
        hdr(7'h11, 1'b0, 1'b1, 1'b0);
        stop;
        check("t2_ack_err_held", ack_err, 1);
        // read 0x3C -> 0x96
        req(7'h3C, 1'b1, 8'h00);
        hdr(7'h3C, 1'b1, 1'b0, 1'b0);
        rd_byte(8'h96);
        stop;
        check("t3_rd_data_hold", rd_data, 8'h96);
        // request and data change mid-WR are ignored
        req(7'h2A, 1'b0, 8'h5C);
        hdr(7'h2A, 1'b0, 1'b0, 1'b0);
        wr_byte(8'h5C, 1'b1);
        stop;
        rise;
        fall;
        check("t4_no_queued_busy", busy, 0);
        check("t4_no_queued_sda", sda_oe, 0);
        // data_clk stretched high during ADDR
        req(7'h6B, 1'b0, 8'h3D);
        hdr(7'h6B, 1'b0, 1'b0, 1'b1);
        wr_byte(8'h3D, 1'b0);
        stop;
        // reset mid-WR aborts, then a fresh write completes
        req(7'h22, 1'b0, 8'h3C);
        hdr(7'h22, 1'b0, 1'b0, 1'b0);
        rise;
        check("t5_bit7", sda_oe, 1);
        fall;
        rise;
        check("t5_bit6", sda_oe, 1);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        check("t5_abort_sda_oe", sda_oe, 0);
        check("t5_abort_scl_ne", scl_not_ena, 1);
        check("t5_abort_busy", busy, 0);
        fall;
        check("t5_idle_busy", busy, 0);
        check("t5_idle_sda", sda_oe, 0);
        req(7'h45, 1'b0, 8'hC3);
        hdr(7'h45, 1'b0, 1'b0, 1'b0);
        wr_byte(8'hC3, 1'b0);
        stop;
        check("t5_ack_err", ack_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
